// File: rtl/watermark_engine.sv
// watermark_engine: APB-programmed pixel/watermark buffer streamed through an alpha/beta blend.
// Build macro WM_SATURATE_EN clamps the blended result; without it the result wraps.
module watermark_engine #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 12,
  parameter int Data_Depth      = 8,
  parameter int Mem_Addr_W      = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [Amba_Addr_Depth-1:0] PADDR,
  input  logic [Amba_Word-1:0]       PWDATA,
  output logic [Amba_Word-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [Data_Depth-1:0]      Pixel_Data,
  output logic                       Pixel_Valid,
  output logic                       Image_Done
);
  localparam int DEPTH = 1 << Mem_Addr_W;
  localparam int CW    = Mem_Addr_W + 1;
  localparam int SW    = 2 * Data_Depth + 1;
  localparam int RA    = Amba_Addr_Depth - 1;
`ifdef WM_SATURATE_EN
  localparam int RW = Data_Depth + 1;
`else
  localparam int RW = Data_Depth;
`endif
  localparam logic [RA-1:0] A_CTRL   = RA'(0);
  localparam logic [RA-1:0] A_STATUS = RA'(1);
  localparam logic [RA-1:0] A_NPIX   = RA'(2);
  localparam logic [RA-1:0] A_ALPHA  = RA'(3);
  localparam logic [RA-1:0] A_BETA   = RA'(4);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           idx_q, idx_d, n_s;
  logic [Amba_Word-1:0]    npix_q, npix_d, prdata_q, prdata_d;
  logic [Data_Depth-1:0]   alpha_q, alpha_d, beta_q, beta_d, pix_q, pix_d;
  logic [2*Data_Depth-1:0] rd_q, rd_d;
  logic [RW-1:0]           r_q, r_d;
  logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                    done_q, done_d, pslverr_q, pslverr_d;
  logic                    setup_s, wr_s, busy_s, buf_sel_s, cfg_sel_s;
  logic                    start_s, abort_s, mem_we_s;
  logic [RA-1:0]           reg_a_s;
  logic [Mem_Addr_W-1:0]   buf_a_s;
  logic [2*Data_Depth-1:0] mem_q [DEPTH];

  // APB decode, config register updates and setup-phase read/error capture
  always_comb begin
    setup_s   = PSEL && !PENABLE;
    wr_s      = PSEL && PENABLE && PWRITE;
    busy_s    = (state_q == RUN) || (state_q == DRAIN);
    buf_sel_s = PADDR[Amba_Addr_Depth-1];
    reg_a_s   = PADDR[RA-1:0];
    buf_a_s   = PADDR[Mem_Addr_W-1:0];
    cfg_sel_s = !buf_sel_s && ((reg_a_s == A_NPIX) || (reg_a_s == A_ALPHA) || (reg_a_s == A_BETA));
    abort_s   = wr_s && !buf_sel_s && (reg_a_s == A_CTRL) && PWDATA[1];
    start_s   = wr_s && !buf_sel_s && (reg_a_s == A_CTRL) && PWDATA[0] && !PWDATA[1];
    mem_we_s  = wr_s && buf_sel_s && !busy_s;
    npix_d    = npix_q;
    alpha_d   = alpha_q;
    beta_d    = beta_q;
    if (wr_s && cfg_sel_s && !busy_s) begin
      case (reg_a_s)
        A_NPIX:  npix_d  = PWDATA;
        A_ALPHA: alpha_d = PWDATA[Data_Depth-1:0];
        A_BETA:  beta_d  = PWDATA[Data_Depth-1:0];
        default: npix_d  = npix_q;
      endcase
    end else begin
      npix_d = npix_q;
    end
    // PRDATA/PSLVERR are registered at the SETUP edge so they are valid throughout ACCESS
    prdata_d  = '0;
    pslverr_d = 1'b0;
    if (setup_s) begin
      pslverr_d = busy_s && (buf_sel_s || (PWRITE && cfg_sel_s));
      if (PWRITE) begin
        prdata_d = '0;
      end else if (buf_sel_s) begin
        prdata_d = busy_s ? '0 : Amba_Word'(mem_q[buf_a_s]);
      end else begin
        case (reg_a_s)
          A_STATUS: prdata_d = Amba_Word'({state_q == DONE, busy_s});
          A_NPIX:   prdata_d = npix_q;
          A_ALPHA:  prdata_d = Amba_Word'(alpha_q);
          A_BETA:   prdata_d = Amba_Word'(beta_q);
          default:  prdata_d = '0;
        endcase
      end
    end else begin
      prdata_d = '0;
    end
  end

  // Frame sequencing: read index generation and state transitions
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_s     = (npix_q > Amba_Word'(DEPTH)) ? CW'(DEPTH) : npix_q[CW-1:0];
    if (abort_s) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_s) begin
            idx_d   = '0;
            state_d = (n_s == '0) ? DONE : RUN;
          end else begin
            state_d = state_q;
          end
        end
        RUN: begin
          idx_d = idx_q + CW'(1);
          if (idx_q == n_s - CW'(1)) state_d = DRAIN;
          else                       state_d = RUN;
        end
        DRAIN: begin
          if (!v1_q && !v2_q) state_d = DONE;
          else                state_d = DRAIN;
        end
        default: state_d = IDLE;
      endcase
    end
    done_d = (state_d == DONE);
  end

  // Three-stage pixel pipeline: buffer read, multiply-add, output
  always_comb begin
    v1_d  = (state_q == RUN) && !abort_s;
    v2_d  = v1_q && !abort_s;
    v3_d  = v2_q && !abort_s;
    rd_d  = (state_q == RUN) ? mem_q[idx_q[Mem_Addr_W-1:0]] : '0;
    r_d   = RW'((SW'(rd_q[Data_Depth-1:0]) * SW'(alpha_q) +
                 SW'(rd_q[2*Data_Depth-1:Data_Depth]) * SW'(beta_q)) >> Data_Depth);
    pix_d = '0;
    if (v2_q && !abort_s) begin
`ifdef WM_SATURATE_EN
      pix_d = r_q[Data_Depth] ? '1 : r_q[Data_Depth-1:0];
`else
      pix_d = r_q;
`endif
    end else begin
      pix_d = '0;
    end
  end

  // State, configuration and pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      npix_q    <= '0;
      alpha_q   <= '0;
      beta_q    <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      rd_q      <= '0;
      r_q       <= '0;
      pix_q     <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      npix_q    <= npix_d;
      alpha_q   <= alpha_d;
      beta_q    <= beta_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      rd_q      <= rd_d;
      r_q       <= r_d;
      pix_q     <= pix_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      done_q    <= done_d;
    end
  end

  // Pixel buffer storage; contents are not reset
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_q[buf_a_s] <= PWDATA[2*Data_Depth-1:0];
  end

  assign PRDATA      = prdata_q;
  assign PREADY      = 1'b1;
  assign PSLVERR     = pslverr_q;
  assign Pixel_Data  = pix_q;
  assign Pixel_Valid = v3_q;
  assign Image_Done  = done_q;
endmodule

// File: tb/tb_watermark_engine.sv
// Self-checking bench for watermark_engine: randomized images compared with an arithmetic model.
`timescale 1ns/1ps
module tb_watermark_engine;
  logic        clk = 1'b0, rst = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:0] PADDR = 12'd0;
  logic [15:0] PWDATA = 16'd0;
  logic [15:0] PRDATA;
  logic        PREADY, PSLVERR, Pixel_Valid, Image_Done;
  logic [7:0]  Pixel_Data;

  watermark_engine dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .Pixel_Data(Pixel_Data), .Pixel_Valid(Pixel_Valid),
    .Image_Done(Image_Done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int mp [1024];
  int mw [1024];
  int alpha_m = 0, beta_m = 0, start_c = 0, exp_n = 0, zero_viol = 0;
  int px_v[$], px_c[$], exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (Pixel_Valid) begin
      px_v.push_back(int'(Pixel_Data));
      px_c.push_back(cyc);
    end else if (Pixel_Data !== 8'd0) begin
      zero_viol++;
    end
  end

  function automatic int blend(int a, int b, int p, int w);
    int r;
    r = (a * p + b * w) >> 8;
`ifdef WM_SATURATE_EN
    if (r > 255) r = 255;
`else
    r = r % 256;
`endif
    return r;
  endfunction

  task automatic apb(input bit w, input logic [11:0] a, input logic [15:0] d,
                     output logic [15:0] rdat, output logic err);
    @(negedge clk); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(negedge clk); PENABLE = 1'b1;
    #1; rdat = PRDATA; err = PSLVERR;
    @(posedge clk); #1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    logic [15:0] r; logic e;
    apb(1'b1, a, d, r, e);
  endtask

  task automatic buf_wr(input int i, input int p, input int w);
    wr(12'h800 | 12'(i), {8'(w), 8'(p)});
    mp[i] = p; mw[i] = w;
  endtask

  task automatic set_cfg(input int n, input int a, input int b);
    wr(12'h002, 16'(n)); wr(12'h003, 16'(a)); wr(12'h004, 16'(b));
    alpha_m = a; beta_m = b;
  endtask

  task automatic fill_rand(input int cnt);
    for (int i = 0; i < cnt; i++) buf_wr(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  task automatic start_image(input int n);
    px_v.delete(); px_c.delete(); exp_q.delete(); zero_viol = 0;
    exp_n = (n > 1024) ? 1024 : n;
    for (int i = 0; i < exp_n; i++) exp_q.push_back(blend(alpha_m, beta_m, mp[i], mw[i]));
    wr(12'h000, 16'h0001);
    start_c = cyc;
  endtask

  task automatic finish_image(input string nm);
    int k = 0, bad = 0, bad_i = -1;
    do begin @(negedge clk); k++; end while (Image_Done !== 1'b1 && k < exp_n + 40);
    checks++;
    if (Image_Done !== 1'b1) begin errors++; $display("FAIL %s done_timeout got %b want 1", nm, Image_Done); end
    checks++;
    if (cyc !== start_c + ((exp_n == 0) ? 0 : exp_n + 3)) begin
      errors++; $display("FAIL %s done_cycle got %0d want %0d", nm, cyc - start_c, (exp_n == 0) ? 0 : exp_n + 3);
    end
    checks++;
    if (px_v.size() !== exp_n) begin errors++; $display("FAIL %s pixel_count got %0d want %0d", nm, px_v.size(), exp_n); end
    if (exp_n > 0 && px_v.size() == exp_n) begin
      checks++;
      if (px_c[0] !== start_c + 3 || px_c[exp_n-1] !== start_c + 2 + exp_n) begin
        errors++; $display("FAIL %s pixel_timing got first %0d last %0d want %0d %0d", nm,
                           px_c[0] - start_c, px_c[exp_n-1] - start_c, 3, exp_n + 2);
      end
      for (int i = 0; i < exp_n; i++) if (px_v[i] !== exp_q[i]) begin bad++; if (bad_i < 0) bad_i = i; end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL %s pixel_data %0d bad, first idx %0d got %0d want %0d", nm, bad, bad_i, px_v[bad_i], exp_q[bad_i]);
      end
    end
    checks++;
    if (zero_viol != 0) begin errors++; $display("FAIL %s data_when_invalid got %0d cycles want 0", nm, zero_viol); end
  endtask

  task automatic test_reset();
    logic [15:0] r; logic e;
    repeat (3) @(negedge clk);
    checks++;
    if ({PRDATA, PSLVERR, Pixel_Data, Pixel_Valid, Image_Done} !== 27'd0 || PREADY !== 1'b1) begin
      errors++; $display("FAIL reset_outputs got %h %b %h %b %b ready %b want 0 0 0 0 0 ready 1",
                         PRDATA, PSLVERR, Pixel_Data, Pixel_Valid, Image_Done, PREADY);
    end
    rst = 1'b1;
    apb(1'b0, 12'h001, 16'd0, r, e);
    checks++; if (r !== 16'd0) begin errors++; $display("FAIL reset_status got %h want 0", r); end
    apb(1'b0, 12'h002, 16'd0, r, e);
    checks++; if (r !== 16'd0) begin errors++; $display("FAIL reset_npix got %h want 0", r); end
  endtask

  task automatic test_readback();
    logic [15:0] r, v; logic e;
    set_cfg(37, 200, 17);
    apb(1'b0, 12'h002, 16'd0, r, e);
    checks++; if (r !== 16'd37) begin errors++; $display("FAIL rb_npix got %0d want 37", r); end
    apb(1'b0, 12'h003, 16'd0, r, e);
    checks++; if (r !== 16'd200) begin errors++; $display("FAIL rb_alpha got %0d want 200", r); end
    wr(12'h005, 16'hBEEF);
    apb(1'b0, 12'h005, 16'd0, r, e);
    checks++; if (r !== 16'd0) begin errors++; $display("FAIL rb_unmapped got %h want 0", r); end
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom);
      wr(12'h800 | 12'(i * 77), v);
      apb(1'b0, 12'h800 | 12'(i * 77), 16'd0, r, e);
      checks++;
      if (r !== v || e !== 1'b0) begin errors++; $display("FAIL rb_buffer got %h err %b want %h err 0", r, e, v); end
    end
  endtask

  task automatic test_basic();
    buf_wr(0, 100, 200);
    set_cfg(1, 128, 128);
    start_image(1);
    finish_image("basic");
    checks++;
    if (px_v.size() != 1 || px_v[0] != 150) begin errors++; $display("FAIL basic_value got %0d want 150", px_v[0]); end
  endtask

  task automatic test_saturate();
    int want;
`ifdef WM_SATURATE_EN
    want = 255;
`else
    want = 252;
`endif
    buf_wr(0, 255, 255);
    set_cfg(1, 255, 255);
    start_image(1);
    finish_image("saturate");
    checks++;
    if (px_v.size() != 1 || px_v[0] != want) begin errors++; $display("FAIL saturate_value got %0d want %0d", px_v[0], want); end
  endtask

  task automatic test_back_to_back();
    int want [4] = '{0, 9, 19, 29};
    for (int i = 0; i < 4; i++) buf_wr(i, i * 10, 0);
    set_cfg(4, 255, 0);
    start_image(4);
    finish_image("ramp");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (px_v.size() != 4 || px_v[i] != want[i]) begin errors++; $display("FAIL ramp_value[%0d] got %0d want %0d", i, px_v[i], want[i]); end
    end
  endtask

  task automatic test_random();
    fill_rand(64);
    for (int t = 0; t < 4; t++) begin
      set_cfg(int'($urandom_range(1, 64)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      start_image(int'(dut.npix_q) == 0 ? 1 : int'(dut.npix_q[6:0]));
      finish_image("random");
    end
  endtask

  task automatic test_npix_zero();
    set_cfg(0, 10, 10);
    start_image(0);
    finish_image("npix_zero");
  endtask

  task automatic test_busy();
    logic [15:0] r; logic e;
    fill_rand(40);
    set_cfg(30, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    start_image(30);
    apb(1'b1, 12'h803, 16'h1234, r, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL busy_buf_write_err got %b want 1", e); end
    apb(1'b0, 12'h803, 16'd0, r, e);
    checks++; if (e !== 1'b1 || r !== 16'd0) begin errors++; $display("FAIL busy_buf_read got %h err %b want 0 err 1", r, e); end
    apb(1'b1, 12'h003, 16'd7, r, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL busy_alpha_err got %b want 1", e); end
    apb(1'b0, 12'h001, 16'd0, r, e);
    checks++; if (r !== 16'd1) begin errors++; $display("FAIL busy_status got %h want 1", r); end
    wr(12'h000, 16'h0001);
    finish_image("busy");
    apb(1'b0, 12'h803, 16'd0, r, e);
    checks++;
    if (r !== {8'(mw[3]), 8'(mp[3])} || e !== 1'b0) begin
      errors++; $display("FAIL busy_buf_unchanged got %h err %b want %h err 0", r, e, {8'(mw[3]), 8'(mp[3])});
    end
  endtask

  task automatic test_abort();
    logic [15:0] r; logic e;
    int k = 0, n_at;
    fill_rand(1024);
    set_cfg(1024, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    start_image(1024);
    while (px_v.size() < 500 && k < 700) begin @(negedge clk); k++; end
    checks++; if (px_v.size() < 500) begin errors++; $display("FAIL abort_reach500 got %0d want 500", px_v.size()); end
    wr(12'h000, 16'h0002);
    @(negedge clk);
    checks++;
    if (Pixel_Valid !== 1'b0 || Image_Done !== 1'b0) begin
      errors++; $display("FAIL abort_flush got valid %b done %b want 0 0", Pixel_Valid, Image_Done);
    end
    n_at = px_v.size();
    for (int i = 0; i < n_at; i++) if (px_v[i] !== exp_q[i]) k = -1;
    checks++; if (k < 0) begin errors++; $display("FAIL abort_prefix got mismatch want %0d correct", n_at); end
    repeat (10) @(negedge clk);
    checks++; if (px_v.size() !== n_at) begin errors++; $display("FAIL abort_no_more got %0d want %0d", px_v.size(), n_at); end
    apb(1'b0, 12'h001, 16'd0, r, e);
    checks++; if (r !== 16'd0) begin errors++; $display("FAIL abort_status got %h want 0", r); end
    wr(12'h000, 16'h0003);
    repeat (8) @(negedge clk);
    apb(1'b0, 12'h001, 16'd0, r, e);
    checks++;
    if (r !== 16'd0 || px_v.size() !== n_at) begin
      errors++; $display("FAIL abort_wins got status %h pixels %0d want 0 %0d", r, px_v.size(), n_at);
    end
    set_cfg(2000, alpha_m, beta_m);
    start_image(2000);
    finish_image("npix_clamp");
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; logic e;
    set_cfg(8, 128, 64);
    start_image(8);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({PRDATA, PSLVERR, Pixel_Data, Pixel_Valid, Image_Done} !== 27'd0) begin
      errors++; $display("FAIL midreset_outputs got %h %b %h %b %b want all 0", PRDATA, PSLVERR, Pixel_Data, Pixel_Valid, Image_Done);
    end
    @(negedge clk); rst = 1'b1;
    px_v.delete(); px_c.delete();
    repeat (20) @(negedge clk);
    checks++; if (px_v.size() !== 0) begin errors++; $display("FAIL midreset_no_pixels got %0d want 0", px_v.size()); end
    apb(1'b0, 12'h002, 16'd0, r, e);
    checks++; if (r !== 16'd0) begin errors++; $display("FAIL midreset_npix got %0d want 0", r); end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_random();
    test_npix_zero();
    test_busy();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/watermark_engine.md
WATERMARK_ENGINE -- requirements
Module: watermark_engine

Interface
REQ-001 Amba_Word, 16, APB data width; SHALL be >= 2*Data_Depth.
REQ-002 Amba_Addr_Depth, 12, APB address width.
REQ-003 Data_Depth, 8, pixel bit depth.
REQ-004 Mem_Addr_W, 10, pixel buffer index width; depth 2**Mem_Addr_W.
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 PSEL, PENABLE, PWRITE  input  1 each  APB control.
REQ-008 PADDR  input  Amba_Addr_Depth  APB address.
REQ-009 PWDATA  input  Amba_Word  APB write data.
REQ-010 PRDATA  output  Amba_Word  APB read data, registered.
REQ-011 PREADY  output  1  tied high, no wait states.
REQ-012 PSLVERR  output  1  error on rejected access.
REQ-013 Pixel_Data  output  Data_Depth  blended pixel.
REQ-014 Pixel_Valid  output  1  Pixel_Data qualifier, one pixel per cycle.
REQ-015 Image_Done  output  1  level, image complete.

Function
REQ-016 Access occurs in the APB ACCESS phase (PSEL&PENABLE); writes SHALL commit on that edge; PRDATA SHALL be valid in the same ACCESS cycle.
REQ-017 PADDR[Amba_Addr_Depth-1]=0 selects registers: 0x0 CTRL (bit0 START write-1 self-clearing, bit1 ABORT write-1 self-clearing), 0x1 STATUS RO (bit0 busy, bit1 done), 0x2 NPIX, 0x3 ALPHA[Data_Depth-1:0], 0x4 BETA[Data_Depth-1:0]; other register addresses SHALL read 0 and ignore writes.
REQ-018 PADDR[Amba_Addr_Depth-1]=1 selects buffer word PADDR[Mem_Addr_W-1:0]: primary P in bits [Data_Depth-1:0], watermark W in bits [2*Data_Depth-1:Data_Depth].
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; START in IDLE or DONE -> RUN, clears Image_Done; START in RUN/DRAIN SHALL be ignored.
REQ-020 RUN issues one buffer read per cycle, index 0..N-1, N=min(NPIX, 2**Mem_Addr_W); after index N-1 -> DRAIN; DRAIN lasts until the pipeline is empty, then -> DONE with Image_Done=1.
REQ-021 Pipeline: buffer read (1 cycle), multiply-add register (1 cycle), output register; the first Pixel_Valid SHALL assert 3 cycles after the START write edge; N consecutive valid cycles follow, no bubbles.
REQ-022 Blend: S = ALPHA*P + BETA*W, width 2*Data_Depth+1; R = S >> Data_Depth.
REQ-023 NPIX=0: START SHALL go to DONE on the next cycle with no Pixel_Valid.
REQ-024 ABORT in any state SHALL return to IDLE next cycle, flush the pipeline (Pixel_Valid=0), leave Image_Done=0; ABORT and START on the same write: ABORT wins.
REQ-025 Buffer or NPIX/ALPHA/BETA write while busy SHALL be dropped with PSLVERR=1 for that ACCESS cycle; buffer read while busy returns 0 with PSLVERR=1.
REQ-026 Pixel_Data SHALL be 0 whenever Pixel_Valid=0.

Reset
REQ-027 rst low SHALL force IDLE, all registers 0, PRDATA=0, PSLVERR=0, Pixel_Data=0, Pixel_Valid=0, Image_Done=0; buffer contents undefined.
REQ-028 rst asserted mid-image SHALL abandon the image; no Pixel_Valid after release until a new START.

Configuration
REQ-029 Macro WM_SATURATE_EN defined: Pixel_Data = R clamped to 2**Data_Depth-1.
REQ-030 WM_SATURATE_EN undefined: Pixel_Data = R[Data_Depth-1:0] (wrap); no clamp logic generated.

Verification
REQ-031 ALPHA=128, BETA=128, buffer[0]={W=200,P=100}, NPIX=1, START -> single Pixel_Valid 3 cycles later, Pixel_Data=150, then Image_Done=1.
REQ-032 ALPHA=BETA=255, P=W=255, NPIX=1 -> Pixel_Data=255 with WM_SATURATE_EN, 252 without.
REQ-033 NPIX=4, buffers {P=i*10, W=0}, ALPHA=255, BETA=0 -> 4 back-to-back valids: 0, 9, 19, 29; Image_Done set after last.
REQ-034 NPIX=1024 running, write ABORT at pixel 500 -> Pixel_Valid low within 1 cycle, STATUS=0, Image_Done=0.
REQ-035 During RUN, write buffer[3] and START -> PSLVERR=1 on the write, buffer unchanged, image proceeds normally.
REQ-036 NPIX=0, START -> Image_Done=1 next cycle, no Pixel_Valid; rst low mid-image (NPIX=8) -> all outputs 0 immediately.
